// File: rtl/bus_responder_pkg.sv
// rtl/bus_responder_pkg.sv - shared encodings and address map for the data-memory bus target
package bus_responder_pkg;

  // access size encoding carried in mem_ctrl
  localparam logic [1:0] TYPE_WORD = 2'b00;
  localparam logic [1:0] TYPE_HALF = 2'b01;
  localparam logic [1:0] TYPE_BYTE = 2'b10;

  // mem_ctrl = {unsigned, type[1:0], we}
  localparam int CTRL_WE_BIT       = 0;
  localparam int CTRL_TYPE_LSB     = 1;
  localparam int CTRL_TYPE_MSB     = 2;
  localparam int CTRL_UNSIGNED_BIT = 3;

  // everything at or above IO_BASE is the peripheral window
  localparam logic [31:0] IO_BASE     = 32'hFFFF_F000;
  localparam logic [11:0] IO_OFF_DISP = 12'h000;
  localparam logic [11:0] IO_OFF_TCNT = 12'h020;
  localparam logic [11:0] IO_OFF_TDIV = 12'h024;
  localparam logic [11:0] IO_OFF_LED  = 12'h060;
  localparam logic [11:0] IO_OFF_SW   = 12'h070;

  localparam int IO_BUS_WIDTH_WORD = 32;
  localparam int IO_BUS_WIDTH_HALF = 16;
  localparam int IO_BUS_WIDTH_BYTE = 8;

  // natural alignment: bytes anywhere, halves on even, words on multiples of 4
  function automatic logic is_aligned(input logic [1:0] acc_type, input logic [1:0] lo);
    case (acc_type)
      TYPE_BYTE: return 1'b1;
      TYPE_HALF: return ~lo[0];
      default:   return (lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/bus_responder_seg_scan.sv
// rtl/bus_responder_seg_scan.sv - 8-digit multiplexed 7-segment scanner with hex glyph ROM
module seg_scan
  import bus_responder_pkg::*;
#(
  parameter int SCAN_DIV = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] disp,
  output logic [7:0]  seg_en,
  output logic [7:0]  seg_code
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [3:0]    nib;
  logic [7:0]    glyph;

  assign nib = disp[{idx_q, 2'b00} +: 4];

  // hex glyph ROM, active-low {dp,g,f,e,d,c,b,a}, decimal point always dark
  always_comb begin
    glyph = 8'hFF;
    case (nib)
      4'h0: glyph = 8'hC0;
      4'h1: glyph = 8'hF9;
      4'h2: glyph = 8'hA4;
      4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;
      4'h5: glyph = 8'h92;
      4'h6: glyph = 8'h82;
      4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;
      4'h9: glyph = 8'h90;
      4'hA: glyph = 8'h88;
      4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;
      4'hD: glyph = 8'hA1;
      4'hE: glyph = 8'h86;
      4'hF: glyph = 8'h8E;
      default: glyph = 8'hFF;
    endcase
  end

  // slot timer advances the digit index; outputs are registered from the pre-edge index
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      seg_en   <= 8'hFE;
      seg_code <= 8'hC0;
    end else begin
      if (cnt_q == CW'(SCAN_DIV - 1)) begin
        cnt_q <= '0;
        idx_q <= idx_q + 3'd1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      seg_en   <= ~(8'b1 << idx_q);
      seg_code <= glyph;
    end
  end

endmodule

// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - data-memory bus target: DRAM port, load/store lanes, IO registers
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter int DRAM_AW  = 14,
  parameter int SW_W     = 24,
  parameter int SCAN_DIV = 20000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        mem_addr,
  input  logic [3:0]         mem_ctrl,
  input  logic [31:0]        mem_wd,
  input  logic               mem_we,
  output logic [31:0]        mem_rd,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic [31:0]        dram_wdin,
  output logic               dram_we,
  input  logic [31:0]        dram_rdo,
  input  logic [SW_W-1:0]    sw,
  output logic [SW_W-1:0]    led,
  output logic [7:0]         seg_en,
  output logic [7:0]         seg_code,
  output logic               bus_err
);

  logic [1:0]      acc_type;
  logic            acc_uns;
  logic [1:0]      lane;
  logic            io_hit;
  logic            aligned;
  logic [11:0]     io_off;
  logic            wr_word;
  logic            wr_disp, wr_tcnt, wr_tdiv, wr_led;
  logic [31:0]     disp_q, tcnt_q, tdiv_q, presc_q;
  logic [SW_W-1:0] sw_s1, sw_s2;
  logic [31:0]     io_rd, src, shifted;
  // the store strobe is mem_we; the copy inside mem_ctrl is redundant
  logic            ctrl_we_unused;

  assign ctrl_we_unused = mem_ctrl[CTRL_WE_BIT];
  assign acc_type  = mem_ctrl[CTRL_TYPE_MSB:CTRL_TYPE_LSB];
  assign acc_uns   = mem_ctrl[CTRL_UNSIGNED_BIT];
  assign lane      = mem_addr[1:0];
  assign io_hit    = (mem_addr >= IO_BASE);
  assign aligned   = is_aligned(acc_type, lane);
  assign io_off    = {mem_addr[11:2], 2'b00};
  assign dram_addr = mem_addr[DRAM_AW+1:2];
  assign dram_we   = mem_we & ~io_hit & aligned;

  assign wr_word = mem_we & io_hit & aligned & (acc_type == TYPE_WORD);
  assign wr_disp = wr_word & (io_off == IO_OFF_DISP);
  assign wr_tcnt = wr_word & (io_off == IO_OFF_TCNT);
  assign wr_tdiv = wr_word & (io_off == IO_OFF_TDIV);
  assign wr_led  = wr_word & (io_off == IO_OFF_LED);

  // register window read mux; unmapped offsets read zero
  always_comb begin
    io_rd = '0;
    case (io_off)
      IO_OFF_DISP: io_rd = disp_q;
      IO_OFF_TCNT: io_rd = tcnt_q;
      IO_OFF_TDIV: io_rd = tdiv_q;
      IO_OFF_LED:  io_rd[SW_W-1:0] = led;
      IO_OFF_SW:   io_rd[SW_W-1:0] = sw_s2;
      default:     io_rd = '0;
    endcase
  end

  // load path: pick source word, shift lane down, then size and extend
  always_comb begin
    src     = io_hit ? io_rd : dram_rdo;
    shifted = src >> {lane, 3'b000};
    mem_rd  = '0;
    if (aligned) begin
      case (acc_type)
        TYPE_BYTE: mem_rd = {{(IO_BUS_WIDTH_WORD-IO_BUS_WIDTH_BYTE){~acc_uns & shifted[IO_BUS_WIDTH_BYTE-1]}},
                             shifted[IO_BUS_WIDTH_BYTE-1:0]};
        TYPE_HALF: mem_rd = {{(IO_BUS_WIDTH_WORD-IO_BUS_WIDTH_HALF){~acc_uns & shifted[IO_BUS_WIDTH_HALF-1]}},
                             shifted[IO_BUS_WIDTH_HALF-1:0]};
        default:   mem_rd = shifted;
      endcase
    end
  end

  // store path: single-cycle read-modify-write of the addressed lane into the DRAM word
  always_comb begin
    dram_wdin = dram_rdo;
    case (acc_type)
      TYPE_BYTE: dram_wdin[{lane, 3'b000} +: IO_BUS_WIDTH_BYTE] = mem_wd[IO_BUS_WIDTH_BYTE-1:0];
      TYPE_HALF: dram_wdin[{lane[1], 4'b0000} +: IO_BUS_WIDTH_HALF] = mem_wd[IO_BUS_WIDTH_HALF-1:0];
      default:   dram_wdin = mem_wd;
    endcase
  end

  // CPU-visible registers and timer; a count write beats a same-cycle tick, divisor write restarts the period
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q  <= '0;
      tcnt_q  <= '0;
      tdiv_q  <= '0;
      presc_q <= '0;
      led     <= '0;
    end else begin
      if (wr_disp) disp_q <= mem_wd;
      if (wr_led)  led    <= mem_wd[SW_W-1:0];
      if (wr_tdiv) tdiv_q <= mem_wd;
      if (wr_tcnt) begin
        tcnt_q  <= mem_wd;
        presc_q <= '0;
      end else if (wr_tdiv) begin
        presc_q <= '0;
      end else if (presc_q == tdiv_q) begin
        presc_q <= '0;
        tcnt_q  <= tcnt_q + 32'd1;
      end else begin
        presc_q <= presc_q + 32'd1;
      end
    end
  end

  // two-flop synchroniser for the asynchronous switches
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  end

  // sticky error: misaligned access, or a sub-word store into the register window
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err <= 1'b0;
    end else if (~aligned | (mem_we & io_hit & (acc_type != TYPE_WORD))) begin
      bus_err <= 1'b1;
    end
  end

  seg_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_seg_scan (
    .clk      (clk),
    .rst      (rst),
    .disp     (disp_q),
    .seg_en   (seg_en),
    .seg_code (seg_code)
  );

endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - scoreboard bench for bus_responder against a behavioural model
module tb_bus_responder;

  localparam int SD = 2;
  localparam logic [1:0] W = 2'b00, H = 2'b01, B = 2'b10;
  localparam logic [31:0] A_DISP = 32'hFFFF_F000, A_TCNT = 32'hFFFF_F020,
                          A_TDIV = 32'hFFFF_F024, A_LED = 32'hFFFF_F060, A_SW = 32'hFFFF_F070;
  localparam logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  localparam logic [11:0] IO_OFFS [7] = '{12'h000, 12'h020, 12'h024, 12'h060, 12'h070, 12'h040, 12'hFFC};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr = '0, mem_wd = '0;
  logic [3:0]  mem_ctrl = '0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_rd, dram_wdin, dram_rdo;
  logic [13:0] dram_addr;
  logic        dram_we;
  logic [23:0] sw = '0, led;
  logic [7:0]  seg_en, seg_code;
  logic        bus_err;

  always #5 clk = ~clk;

  bus_responder #(.DRAM_AW(14), .SW_W(24), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_ctrl(mem_ctrl), .mem_wd(mem_wd),
    .mem_we(mem_we), .mem_rd(mem_rd), .dram_addr(dram_addr), .dram_wdin(dram_wdin),
    .dram_we(dram_we), .dram_rdo(dram_rdo), .sw(sw), .led(led), .seg_en(seg_en),
    .seg_code(seg_code), .bus_err(bus_err)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 'h40) return 32'h1122_3344;
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // board DRAM: combinational read, written from the DUT's write port
  logic [31:0] env_mem [0:16383];
  assign dram_rdo = env_mem[dram_addr];
  initial for (int i = 0; i < 16384; i++) env_mem[i] <= init_word(i);
  always @(posedge clk) if (dram_we) env_mem[dram_addr] <= dram_wdin;

  // reference model state
  logic [31:0] ref_mem [0:16383];
  logic [31:0] m_disp, m_cnt, m_presc, m_div;
  logic [23:0] m_led;
  logic        m_err;
  logic [7:0]  m_sen, m_scode;
  int          m_n;
  logic [23:0] sw_hist [$];
  logic        p_rst = 1'b1, p_u = 1'b0, p_w = 1'b0;
  logic [1:0]  p_t = W;
  logic [31:0] p_a = '0, p_d = '0;
  logic [23:0] p_sw = '0;

  typedef struct {
    logic [31:0] rd;
    logic        we;
    logic [31:0] wdin;
    logic [23:0] led;
    logic        err;
    logic [7:0]  sen;
    logic [7:0]  scode;
    int          kind;
    logic [31:0] k;
  } item_t;
  item_t sb [$];

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic al_ok(input logic [1:0] t, input logic [31:0] a);
    if (t == B) return 1'b1;
    if (t == H) return a[0] == 1'b0;
    return a[1:0] == 2'b00;
  endfunction

  function automatic logic [31:0] size_mask(input logic [1:0] t);
    return (t == B) ? 32'hFF : (t == H) ? 32'hFFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] m_src(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (a < 32'hFFFF_F000) return ref_mem[a[15:2]];
    if (wa == A_DISP) return m_disp;
    if (wa == A_TCNT) return m_cnt;
    if (wa == A_TDIV) return m_div;
    if (wa == A_LED)  return {8'h0, m_led};
    if (wa == A_SW)   return {8'h0, sw_hist[1]};
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] t, input logic u);
    logic [31:0] v, m;
    if (!al_ok(t, a)) return 32'h0;
    m = size_mask(t);
    v = (m_src(a) >> (8 * a[1:0])) & m;
    if (!u && t == B && v[7])  v = v | 32'hFFFF_FF00;
    if (!u && t == H && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] a,
                                          input logic [1:0] t, input logic [31:0] d);
    logic [31:0] m;
    int          sh;
    m  = size_mask(t);
    sh = 8 * a[1:0];
    return (old & ~(m << sh)) | ((d & m) << sh);
  endfunction

  // advance the model across one clock edge using the inputs held before it
  task automatic model_edge();
    logic        io, al, wr, tick;
    logic [31:0] wa;
    int          idx;
    if (p_rst) begin
      m_disp = 0; m_cnt = 0; m_presc = 0; m_div = 0; m_led = 0; m_err = 0;
      m_sen = 8'hFE; m_scode = 8'hC0; m_n = 0;
      sw_hist = '{24'h0, 24'h0};
      return;
    end
    io = (p_a >= 32'hFFFF_F000);
    al = al_ok(p_t, p_a);
    wa = {p_a[31:2], 2'b00};
    if (p_w && !io && al) ref_mem[p_a[15:2]] = m_merge(ref_mem[p_a[15:2]], p_a, p_t, p_d);
    m_n++;
    idx     = ((m_n - 1) / SD) % 8;
    m_sen   = ~(8'd1 << idx);
    m_scode = GLYPH[(m_disp >> (4 * idx)) & 32'hF];
    sw_hist.push_front(p_sw);
    void'(sw_hist.pop_back());
    if (!al || (p_w && io && p_t != W)) m_err = 1'b1;
    wr   = p_w && io && al && (p_t == W);
    tick = (m_presc == m_div);
    if (wr && wa == A_TCNT) begin
      m_cnt = p_d; m_presc = 0;
    end else if (wr && wa == A_TDIV) begin
      m_presc = 0;
    end else if (tick) begin
      m_presc = 0; m_cnt = m_cnt + 1;
    end else begin
      m_presc = m_presc + 1;
    end
    if (wr && wa == A_TDIV) m_div = p_d;
    if (wr && wa == A_DISP) m_disp = p_d;
    if (wr && wa == A_LED)  m_led = p_d[23:0];
  endtask

  // one bus cycle: update model for the edge, drive new inputs, queue expectations
  task automatic step(input logic r, input logic [31:0] a, input logic [1:0] t, input logic u,
                      input logic w, input logic [31:0] d, input logic [23:0] s,
                      input int kind, input logic [31:0] k);
    item_t it;
    @(posedge clk);
    #1;
    model_edge();
    rst = r; mem_addr = a; mem_ctrl = {u, t, w}; mem_we = w; mem_wd = d; sw = s;
    p_rst = r; p_a = a; p_t = t; p_u = u; p_w = w; p_d = d; p_sw = s;
    if (r) return;
    it.rd    = m_load(a, t, u);
    it.we    = w && (a < 32'hFFFF_F000) && al_ok(t, a);
    it.wdin  = m_merge(ref_mem[a[15:2]], a, t, d);
    it.led   = m_led;
    it.err   = m_err;
    it.sen   = m_sen;
    it.scode = m_scode;
    it.kind  = kind;
    it.k     = k;
    sb.push_back(it);
  endtask

  task automatic idle(input logic [23:0] s, input int kind, input logic [31:0] k);
    step(1'b0, 32'h200, W, 1'b0, 1'b0, 32'h0, s, kind, k);
  endtask

  // monitor: pop one expectation per cycle, compare away from the active edge
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        it = sb.pop_front();
        chk("mem_rd", mem_rd, it.rd);
        chk("dram_we", {31'h0, dram_we}, {31'h0, it.we});
        if (it.we) chk("dram_wdin", dram_wdin, it.wdin);
        chk("led", {8'h0, led}, {8'h0, it.led});
        chk("bus_err", {31'h0, bus_err}, {31'h0, it.err});
        chk("seg_en", {24'h0, seg_en}, {24'h0, it.sen});
        chk("seg_code", {24'h0, seg_code}, {24'h0, it.scode});
        if (it.kind == 1) chk("plan_mem_rd", mem_rd, it.k);
        if (it.kind == 2) chk("plan_dram_wdin", dram_wdin, it.k);
        if (it.kind == 3) chk("plan_seg", {16'h0, seg_en, seg_code}, it.k);
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    logic [1:0]  t, lo;
    logic        w, u;
    logic [11:0] off;
    logic [23:0] s;
    for (int i = 0; i < 16384; i++) ref_mem[i] = init_word(i);
    sw_hist = '{24'h0, 24'h0};

    repeat (3) step(1'b1, 32'h0, W, 1'b0, 1'b0, 32'h0, 24'h0, 0, 0);
    // display scan from reset with SCAN_DIV=2
    step(1'b0, A_DISP, W, 1'b0, 1'b1, 32'h0000_00A5, 24'h0, 0, 0);
    idle(24'h0, 0, 0);
    idle(24'h0, 3, 32'h0000_FE92);
    idle(24'h0, 3, 32'h0000_FD88);
    // DRAM lane merge and sub-word loads
    step(1'b0, 32'h101, B, 1'b0, 1'b1, 32'h0000_00AB, 24'h0, 2, 32'h1122_AB44);
    step(1'b0, 32'h100, W, 1'b0, 1'b1, 32'h80FF_0000, 24'h0, 0, 0);
    step(1'b0, 32'h102, B, 1'b0, 1'b0, 32'h0, 24'h0, 1, 32'hFFFF_FFFF);
    step(1'b0, 32'h102, B, 1'b1, 1'b0, 32'h0, 24'h0, 1, 32'h0000_00FF);
    step(1'b0, 32'h102, H, 1'b0, 1'b0, 32'h0, 24'h0, 1, 32'hFFFF_80FF);
    // LED
    step(1'b0, A_LED, W, 1'b0, 1'b1, 32'h55, 24'h0, 0, 0);
    step(1'b0, A_LED, W, 1'b0, 1'b0, 32'h0, 24'h0, 1, 32'h55);
    // switch synchroniser latency
    step(1'b0, A_SW, W, 1'b0, 1'b0, 32'h0, 24'h0000F0, 1, 32'h0);
    step(1'b0, A_SW, W, 1'b0, 1'b0, 32'h0, 24'h0000F0, 1, 32'h0);
    step(1'b0, A_SW, W, 1'b0, 1'b0, 32'h0, 24'h0000F0, 1, 32'hF0);
    // timer: divisor 3, count 0, then eight more edges
    step(1'b0, A_TDIV, W, 1'b0, 1'b1, 32'd3, 24'hF0, 0, 0);
    step(1'b0, A_TCNT, W, 1'b0, 1'b1, 32'd0, 24'hF0, 0, 0);
    for (int i = 0; i < 9; i++)
      step(1'b0, A_TCNT, W, 1'b0, 1'b0, 32'h0, 24'hF0, (i == 8) ? 1 : 0, 32'd2);
    repeat (2) step(1'b0, A_TCNT, W, 1'b0, 1'b0, 32'h0, 24'hF0, 0, 0);
    // count write lands on a tick edge
    step(1'b0, A_TCNT, W, 1'b0, 1'b1, 32'h10, 24'hF0, 0, 0);
    for (int i = 0; i < 5; i++)
      step(1'b0, A_TCNT, W, 1'b0, 1'b0, 32'h0, 24'hF0, 1, (i == 4) ? 32'h11 : 32'h10);
    // misaligned word store
    step(1'b0, 32'h103, W, 1'b0, 1'b1, 32'hDEAD_BEEF, 24'hF0, 1, 32'h0);
    repeat (3) idle(24'hF0, 0, 0);

    // randomized traffic with a reset pulse mid-scan
    s = 24'hF0;
    for (int i = 0; i < 600; i++) begin
      if (i >= 300 && i < 303) begin
        step(1'b1, 32'h0, W, 1'b0, 1'b0, 32'h0, s, 0, 0);
        continue;
      end
      t = 2'($urandom_range(0, 2));
      u = 1'($urandom);
      w = ($urandom_range(0, 2) == 0);
      d = $urandom;
      lo = 2'($urandom);
      if ($urandom_range(0, 19) != 0) begin
        if (t == W) lo = 2'b00;
        if (t == H) lo[0] = 1'b0;
      end
      if ($urandom_range(0, 9) < 6) begin
        a = 32'($urandom_range(0, 255)) * 4 + 32'(lo);
        if ($urandom_range(0, 3) == 0) a[31:16] = 16'($urandom_range(0, 16'hFFFE));
      end else begin
        off = IO_OFFS[$urandom_range(0, 6)];
        a = 32'hFFFF_F000 | {20'h0, off} | {30'h0, lo};
        if (off == 12'h024) d = 32'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 7) == 0) s = 24'($urandom);
      step(1'b0, a, t, u, w, d, s, 0, 0);
    end

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Target-side endpoint of the core's data-memory bus (`mem_addr`, `mem_ctrl`, `mem_wd`, `mem_we`, `mem_rd`).
- Decodes the address into a DRAM region and a small memory-mapped peripheral window.
- Performs sub-word load extraction with sign/zero extension, and store byte-lane merge.
- Owns the LED register, switch synchroniser, timer and 7-segment scan logic.
- Sits between the core top and the board-level DRAM and IO pins.

Parameters:
- `DRAM_AW`, 14, word-address width of the DRAM port.
- `SW_W`, 24, switch/LED width.
- `SCAN_DIV`, 20000, clock cycles per 7-segment digit slot (must be ≥ 2).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `mem_addr`  in  32  byte address from the core MEM stage.
- `mem_ctrl`  in  4  `{unsigned, type[1:0], we}`; type encoding: 00 word, 01 half, 10 byte.
- `mem_wd`  in  32  store data, right-aligned.
- `mem_we`  in  1  store strobe.
- `mem_rd`  out  32  load data, combinational, same cycle.
- `dram_addr`  out  `DRAM_AW`  word address = `mem_addr[DRAM_AW+1:2]`.
- `dram_wdin`  out  32  merged store word.
- `dram_we`  out  1  DRAM write enable.
- `dram_rdo`  in  32  DRAM combinational read word.
- `sw`  in  `SW_W`  asynchronous board switches.
- `led`  out  `SW_W`  LED register.
- `seg_en`  out  8  digit enables, one-hot, active-low.
- `seg_code`  out  8  segments `{dp,g,f,e,d,c,b,a}`, active-low.
- `bus_err`  out  1  sticky error flag.

Behaviour:
- Reset values (synchronous, active-high): all of the following are applied at the clock edge while `rst`=1.
  - `led`=0, display register=0, timer count=0, prescaler=0, divisor=0.
  - `seg_en`=8'hFE, `seg_code`=8'hC0, `bus_err`=0, scan counter=0, switch synchroniser=0.
  - Reset mid-scan returns to digit 0.
- Address map:
  - Below 0xFFFF_F000: DRAM.
  - 0xFFFF_F000: display data (R/W), eight nibbles, nibble k shown on digit k.
  - 0xFFFF_F020: timer count (R/W).
  - 0xFFFF_F024: timer divisor (R/W).
  - 0xFFFF_F060: LED (R/W).
  - 0xFFFF_F070: switches (R).
  - Other peripheral addresses read 0; writes to them are ignored.
- Loads (combinational):
  - Select the source word, then shift right by `8*addr[1:0]`.
  - Byte: keep 8 bits; half: keep 16 bits.
  - Sign-extend when `unsigned`=0, otherwise zero-extend.
  - Register reads return the pre-edge value; there is no read-during-write bypass.
- Alignment:
  - Half loads/stores require `addr[0]`=0; word loads/stores require `addr[1:0]`=0.
  - A misaligned access returns `mem_rd`=0, suppresses any write, and sets `bus_err` on the next edge.
- DRAM stores:
  - `dram_we` = `mem_we` & DRAM hit & aligned, asserted in the same cycle.
  - Sub-word stores merge `mem_wd`'s low lane into `dram_rdo` at the addressed lane. This is a combinational read-modify-write within one cycle.
- Peripheral stores:
  - Word stores only; registers update on the next edge.
  - A sub-word store to the peripheral window is ignored and sets `bus_err`.
- Switches: 2-flop synchroniser; reads reflect a `sw` change after 2 edges.
- Timer:
  - The prescaler counts 0..divisor. When prescaler==divisor it wraps to 0 and count increments by 1, wrapping modulo 2^32.
  - Divisor=0 means the count increments every cycle.
  - A CPU write to count in the same cycle as an increment: the write wins and the prescaler clears.
  - A write to divisor clears the prescaler.
- Display scan:
  - The scan counter counts 0..`SCAN_DIV`-1. At wrap, the digit index advances 0→7→0.
  - `seg_en` and `seg_code` are registered from the current index and nibble, so they show a 1-cycle lag after an index change or a data write.
  - Hex glyph table 0–F; dp always off (1).
- `bus_err` clears only on `rst`.

Decomposition:
- Shared package holds:
  - Type encodings (`TYPE_WORD`, `TYPE_HALF`, `TYPE_BYTE`).
  - The `mem_ctrl` bit positions.
  - The peripheral base addresses and offsets.
  - `IO_BUS_WIDTH_*`.
- One natural sub-module: `seg_scan`, containing the scan counter, index and glyph ROM. It takes the display word as input and drives `seg_en`/`seg_code`.

Test Plan:
- DRAM word 0x1122_3344 at 0x100; store byte 0xAB to 0x101 -> `dram_we`=1, `dram_wdin`=0x1122_AB44 in the same cycle.
- DRAM word 0x80FF_0000:
  - byte load at 0x102, signed -> `mem_rd`=0xFFFF_FFFF; unsigned -> 0x0000_00FF.
  - half load at 0x102, signed -> 0xFFFF_80FF.
- Word store to 0x103 -> `dram_we`=0, `mem_rd`=0, `bus_err`=1 next cycle and held until `rst`.
- Write divisor=3 then hold 8 cycles -> count reads 2.
- In the same cycle as an increment, write count=0x10 -> count reads 0x10, and the next increment occurs 4 cycles later.
- `SCAN_DIV`=2, display word 0x0000_00A5, `rst` pulse:
  - digit 0: `seg_en`=0xFE, `seg_code`=0x92 ("5").
  - after 2 cycles plus the 1-cycle lag, digit 1: `seg_en`=0xFD, `seg_code`=0x88 ("A").
- `sw`=0x00_00F0 applied -> switch read returns 0 for 2 edges, then 0x0000_00F0.
- Word store 0x55 to 0xFFFF_F060 -> `led`=0x55 after the edge.
